inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction-fetch front end directly upstream of the datapath: drives a variable-latency instruction memory
//  over a valid/ready request port, buffers returned words plus their PC in an in-order FIFO, hands them to the
//  datapath via valid/ready. Datapath signals taken branch/jump/jr via redirect; queued and in-flight words are flushed.
// PARAMETERS
//  n        32  instruction and address width (bits)
//  DEPTH    4   FIFO entries (power of 2, >=2)
//  MAX_OUT  4   max imem requests in flight, live plus to-be-dropped (>=1)
//  RESET_PC 0   first fetch address after reset
// PORTS
//  clk             in   1  clock, all state updates on rising edge
//  reset           in   1  synchronous, active-low; 0 at a rising edge resets the block
//  redirect        in   1  1 = discard queue and restart fetch at redirect_pc
//  redirect_pc     in   n  new fetch byte address (low 2 bits ignored, forced 0)
//  imem_req_valid  out  1  request valid
//  imem_req_ready  in   1  memory accepts request this cycle
//  imem_req_addr   out  n  byte address of request = fetch_pc
//  imem_resp_valid in   1  response word valid (in order; no backpressure)
//  imem_resp_data  in   n  response instruction word
//  inst_valid      out  1  instruction/inst_pc valid to datapath
//  inst_ready      in   1  datapath consumes head this cycle
//  instruction     out  n  head instruction word; 0 when inst_valid=0
//  inst_pc         out  n  byte address of head word; 0 when inst_valid=0
//  err             out  1  sticky: response arrived with nothing outstanding
// BEHAVIOUR
//  Reset (reset=0 at edge): fetch_pc<=RESET_PC, FIFO empty (count=0), live_out=0, drop_cnt=0, err=0,
//   state<=IDLE. Outputs: imem_req_valid=0, inst_valid=0, instruction=0, inst_pc=0. Overrides all else.
//  States: IDLE (one cycle after reset, no request) -> FETCH. FETCH -> FLUSH on redirect when live_out+resp-accepts
//   would leave drop_cnt>0; FLUSH -> FETCH once drop_cnt reaches 0. Requests may issue in FETCH and FLUSH.
//  Issue: imem_req_valid = (state!=IDLE) & !redirect & (count+live_out < DEPTH) & (live_out+drop_cnt < MAX_OUT).
//   All terms are registered state except redirect. Handshake = valid & ready: live_out+1, fetch_pc += 4 (wraps mod 2^n).
//   imem_req_addr/valid hold stable while valid=1 and ready=0, unless redirect.
//  Response: if drop_cnt>0: drop_cnt-1, word discarded. Else if live_out>0: push {word, pc} to FIFO tail, live_out-1.
//   PC tag = address of the oldest live request (tag FIFO). Else err<=1 and word discarded.
//   Credit check guarantees the FIFO never overflows.
//  Output: inst_valid = count>0; head is registered (response at cycle t is visible at t+1). Pop when valid & ready.
//   Push and pop in the same cycle: count unchanged. Pop frees issue credit only from the next cycle.
//  Redirect (priority over push/pop/issue in that cycle): count<=0; drop_cnt <= drop_cnt + live_out -
//   (response consumed this cycle ? 1 : 0); live_out<=0; fetch_pc <= {redirect_pc[n-1:2],2'b00}.
//   Response in redirect cycle: always discarded. inst_ready in redirect cycle: ignored.
//  Min latency: req accepted at t, resp at t+1, inst_valid at t+2. Throughput 1 word/cycle with MAX_OUT>=2.
//  Counter widths: count, live_out and drop_cnt sized to hold DEPTH / MAX_OUT without wrap.
// TESTING
//  T1 reset, imem 1-cycle latency, ready=1, inst_ready=1 -> inst_pc 0,4,8,12 back-to-back; words match memory; err=0.
//  T2 inst_ready=0, memory always ready -> exactly DEPTH=4 requests issued then imem_req_valid=0; raise inst_ready ->
//     one new request per pop.
//  T3 imem latency 3, redirect to 0x40 with 2 requests live -> next 2 responses dropped, first inst_valid has
//     inst_pc=0x40, no stale word ever presented.
//  T4 redirect and imem_resp_valid same cycle, FIFO full, inst_ready=1 -> response dropped, count=0 next cycle,
//     no pop counted, fetch_pc=0x40.
//  T5 imem_resp_valid=1 with nothing outstanding -> err=1 sticky until reset=0; FIFO unchanged.
//  T6 reset=0 mid-stream (4 queued, 2 live) -> next cycle all outputs 0; after release first request addr=RESET_PC
//     one cycle later (IDLE).

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +-- inst_fetch_queue ---------------------------------------- rev 1.0 --+
// | Issues imem fetches, queues {word, pc} in order, flushes on redirect.  |
// +------------------------------------------------------------------------+
module inst_fetch_queue #(
   parameter int             n        = 32,
   parameter int             DEPTH    = 4,
   parameter int             MAX_OUT  = 4,
   parameter logic [n-1:0]   RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         redirect,
   input  logic [n-1:0] redirect_pc,
   output logic         imem_req_valid,
   input  logic         imem_req_ready,
   output logic [n-1:0] imem_req_addr,
   input  logic         imem_resp_valid,
   input  logic [n-1:0] imem_resp_data,
   output logic         inst_valid,
   input  logic         inst_ready,
   output logic [n-1:0] instruction,
   output logic [n-1:0] inst_pc,
   output logic         err
);

   localparam int          PTR_W   = $clog2(DEPTH);
   localparam int          CNT_W   = $clog2(DEPTH + 1);
   localparam int          OUT_W   = $clog2(MAX_OUT + 1);
   localparam logic [31:0] DEPTH_L = DEPTH;
   localparam logic [31:0] MAXO_L  = MAX_OUT;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [n-1:0]       fetch_pc;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_next;
   logic [OUT_W-1:0]   live_out;
   logic [OUT_W-1:0]   live_next;
   logic [OUT_W-1:0]   drop_cnt;
   logic [OUT_W-1:0]   drop_next;

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   tag_wr;
   logic [PTR_W-1:0]   tag_rd;

   logic [n-1:0]       data_mem [DEPTH];
   logic [n-1:0]       pc_mem   [DEPTH];
   logic [n-1:0]       tag_mem  [DEPTH];

   logic               room_ok;
   logic               slot_ok;
   logic               req_fire;
   logic               resp_drop;
   logic               resp_live;
   logic               resp_orphan;
   logic               push;
   logic               pop;
   logic               unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Every term except redirect is registered, so a stalled request holds its address.
   assign room_ok        = (32'(count) + 32'(live_out)) < DEPTH_L;
   assign slot_ok        = (32'(live_out) + 32'(drop_cnt)) < MAXO_L;
   assign imem_req_valid = (state != S_IDLE) && !redirect && room_ok && slot_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_drop   = imem_resp_valid && (drop_cnt != '0);
   assign resp_live   = imem_resp_valid && (drop_cnt == '0) && (live_out != '0);
   assign resp_orphan = imem_resp_valid && (drop_cnt == '0) && (live_out == '0);
   assign push        = resp_live && !redirect;

   assign inst_valid  = (count != '0);
   assign pop         = inst_valid && inst_ready && !redirect;
   assign instruction = inst_valid ? data_mem[rd_ptr] : '0;
   assign inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;

   always_comb begin
      count_next = count;
      live_next  = live_out;
      drop_next  = drop_cnt;
      if (redirect) begin
         // Everything still in flight becomes a drop, less the response arriving now.
         count_next = '0;
         live_next  = '0;
         drop_next  = drop_cnt + live_out - OUT_W'(resp_drop || resp_live);
      end else begin
         count_next = count + CNT_W'(push) - CNT_W'(pop);
         live_next  = live_out + OUT_W'(req_fire) - OUT_W'(resp_live);
         drop_next  = drop_cnt - OUT_W'(resp_drop);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  state_next = S_FETCH;
         S_FETCH: if (redirect && (drop_next != '0)) state_next = S_FLUSH;
         S_FLUSH: if (drop_next == '0) state_next = S_FETCH;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         count    <= '0;
         live_out <= '0;
         drop_cnt <= '0;
         err      <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tag_wr   <= '0;
         tag_rd   <= '0;
      end else begin
         count    <= count_next;
         live_out <= live_next;
         drop_cnt <= drop_next;
         if (resp_orphan) begin
            err <= 1'b1;
         end
         if (redirect) begin
            fetch_pc <= {redirect_pc[n-1:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + n'(4);
               tag_wr   <= tag_wr + PTR_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               tag_rd <= tag_rd + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
         end
      end
   end

   // Live requests never exceed DEPTH thanks to the room check, so the tag FIFO cannot overrun.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         tag_mem[tag_wr] <= fetch_pc;
      end
      if (push) begin
         data_mem[wr_ptr] <= imem_resp_data;
         pc_mem[wr_ptr]   <= tag_mem[tag_rd];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// Bench for inst_fetch_queue: directed + random stimulus, imem model, {pc, word} scoreboard.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] instruction;
   logic [31:0] inst_pc;
   logic        err;

   inst_fetch_queue #(
      .n        (32),
      .DEPTH    (DEPTH),
      .MAX_OUT  (MAX_OUT),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .instruction     (instruction),
      .inst_pc         (inst_pc),
      .err             (err)
   );

   typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

   mreq_t       pending[$];
   exp_t        expq[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          hs_total = 0;
   int          pop_total = 0;
   int          last_due = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          in_reset = 1'b1;
   bit          err_exp = 1'b0;
   bit          orphan_now = 1'b0;
   bit          resp_live = 1'b0;
   logic [31:0] model_pc = RESET_PC;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; the imem model answers in order.
   task automatic tick(input bit rdr, input logic [31:0] rpc, input bit irdy, input bit qrdy,
                       input bit orphan);
      @(negedge clk);
      reset          = ~in_reset;
      redirect       = rdr;
      redirect_pc    = rpc;
      inst_ready     = irdy;
      imem_req_ready = qrdy;
      orphan_now     = 1'b0;
      resp_live      = 1'b0;
      if (orphan && pending.size() == 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hDEAD_BEEF;
         orphan_now      = 1'b1;
      end else if (pending.size() > 0 && pending[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = pending[0].data;
         resp_live       = 1'b1;
         void'(pending.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
   endtask

   // Monitor: compares every presented instruction against the scoreboard head.
   initial begin
      int          lat;
      int          d;
      bit          do_pop;
      bit          prev_stall;
      logic [31:0] prev_addr;
      prev_stall = 1'b0;
      prev_addr  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            expq.delete();
            pending.delete();
            model_pc   = RESET_PC;
            err_exp    = 1'b0;
            last_due   = 0;
            prev_stall = 1'b0;
         end else begin
            check("err", 32'(err), 32'(err_exp));
            if (orphan_now) err_exp = 1'b1;
            if (prev_stall && !redirect) begin
               check("req_held_valid", 32'(imem_req_valid), 32'd1);
               check("req_held_addr", imem_req_addr, prev_addr);
            end
            do_pop = 1'b0;
            if (inst_valid) begin
               if (expq.size() == 0) begin
                  check("unexpected_inst_valid", 32'(inst_valid), 32'd0);
               end else begin
                  check("inst_pc", inst_pc, expq[0].pc);
                  check("instruction", instruction, expq[0].word);
                  do_pop = inst_ready && !redirect;
               end
            end else begin
               check("inst_pc_idle_zero", inst_pc, 32'd0);
               check("instruction_idle_zero", instruction, 32'd0);
            end
            if (redirect) begin
               check("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
               expq.delete();
               model_pc   = {redirect_pc[31:2], 2'b00};
               prev_stall = 1'b0;
            end else begin
               if (imem_req_valid && imem_req_ready) begin
                  check("req_addr", imem_req_addr, model_pc);
                  check("fifo_credit", 32'(expq.size() < DEPTH), 32'd1);
                  check("inflight_credit", 32'(pending.size() + int'(resp_live) < MAX_OUT), 32'd1);
                  lat = $urandom_range(lat_hi, lat_lo);
                  d   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                  last_due = d;
                  pending.push_back('{addr: model_pc, data: mem_word(model_pc), due: d});
                  expq.push_back('{pc: model_pc, word: mem_word(model_pc)});
                  model_pc = model_pc + 32'd4;
                  hs_total++;
               end
               if (do_pop) begin
                  void'(expq.pop_front());
                  pop_total++;
               end
               prev_stall = imem_req_valid && !imem_req_ready;
               prev_addr  = imem_req_addr;
            end
         end
      end
   end

   task automatic do_reset();
      in_reset = 1'b1;
      tick(0, 0, 0, 0, 0);
      in_reset = 1'b0;
      tick(0, 0, 0, 0, 0);
      #3;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      tick(0, 0, 0, 0, 0);
      #3;
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, RESET_PC);
   endtask

   task automatic set_lat(input int lo, input int hi);
      lat_lo = lo;
      lat_hi = hi;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) tick(0, 0, 1, 0, 0);
      #3;
      check("drain_scoreboard_empty", 32'(expq.size()), 32'd0);
      check("drain_inst_valid", 32'(inst_valid), 32'd0);
   endtask

   initial begin
      int  h0;
      int  p0;
      int  budget;
      bit  seen;

      // T1: 1-cycle memory, everything ready: back-to-back pcs 0,4,8,12
      set_lat(1, 1);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 1, 0);
         #3;
         if (i >= 2 && i < 6) begin
            check("t1_inst_valid", 32'(inst_valid), 32'd1);
            check("t1_inst_pc", inst_pc, 32'((i - 2) * 4));
         end
      end
      drain();

      // T2: consumer stalled -> exactly DEPTH requests, then one request per pop
      do_reset();
      h0 = hs_total;
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 0);
      #3;
      check("t2_requests_when_full", 32'(hs_total - h0), 32'(DEPTH));
      check("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
      tick(0, 0, 1, 1, 0);
      #3;
      check("t2_pop_valid", 32'(inst_valid), 32'd1);
      h0 = hs_total;
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
      #3;
      check("t2_one_req_per_pop", 32'(hs_total - h0), 32'd1);
      drain();

      // T3: latency 3, redirect with two requests live
      set_lat(3, 3);
      do_reset();
      h0 = hs_total;
      tick(0, 0, 1, 1, 0);
      tick(0, 0, 1, 1, 0);
      #3;
      check("t3_live_before_redirect", 32'(hs_total - h0), 32'd2);
      tick(1, 32'h40, 1, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(0, 0, 1, 1, 0);
         #3;
         if (inst_valid) begin
            check("t3_first_pc_after_redirect", inst_pc, 32'h40);
            seen = 1'b1;
         end
      end
      check("t3_inst_seen", 32'(seen), 32'd1);
      drain();

      // T4: redirect coincides with a response while count+live = DEPTH
      do_reset();
      h0 = hs_total;
      budget = 0;
      while (hs_total - h0 < DEPTH && budget < 12) begin
         tick(0, 0, 0, 1, 0);
         #3;
         budget++;
      end
      check("t4_fill_requests", 32'(hs_total - h0), 32'(DEPTH));
      budget = 0;
      while (!(pending.size() == 1 && pending[0].due == cyc + 1) && budget < 12) begin
         tick(0, 0, 0, 0, 0);
         #3;
         budget++;
      end
      check("t4_setup_reached", 32'(budget < 12), 32'd1);
      tick(1, 32'h43, 1, 0, 0);
      #3;
      check("t4_queue_before_redirect", 32'(inst_valid), 32'd1);
      tick(0, 0, 1, 0, 0);
      #3;
      check("t4_count_zero", 32'(inst_valid), 32'd0);
      check("t4_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_fetch_pc", imem_req_addr, 32'h40);
      check("t4_no_err", 32'(err), 32'd0);
      drain();

      // T5: orphan response sets sticky err and leaves the FIFO alone
      set_lat(1, 1);
      do_reset();
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 1);
      #3;
      check("t5_err_not_yet", 32'(err), 32'd0);
      tick(0, 0, 0, 0, 0);
      #3;
      check("t5_err_set", 32'(err), 32'd1);
      check("t5_fifo_kept", 32'(inst_valid), 32'd1);
      p0 = pop_total;
      for (int i = 0; i < 6; i++) tick(0, 0, 1, 0, 0);
      #3;
      check("t5_fifo_words", 32'(pop_total - p0), 32'd2);
      check("t5_err_sticky", 32'(err), 32'd1);

      // T6: reset mid-stream with words queued and requests live
      set_lat(3, 3);
      do_reset();
      h0 = hs_total;
      budget = 0;
      while (hs_total - h0 < DEPTH && budget < 12) begin
         tick(0, 0, 0, 1, 0);
         #3;
         budget++;
      end
      budget = 0;
      while (pending.size() > 2 && budget < 12) begin
         tick(0, 0, 0, 0, 0);
         #3;
         budget++;
      end
      tick(0, 0, 0, 0, 0);
      #3;
      check("t6_busy_before_reset", 32'(inst_valid), 32'd1);
      do_reset();
      drain();

      // Random traffic against the reference model
      set_lat(1, 4);
      do_reset();
      p0 = pop_total;
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 29) == 0, $urandom, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 7, 1'b0);
      end
      drain();
      check("random_progress", 32'(pop_total - p0 > 300), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
